// File: rtl/axis_maxpool_engine_pkg.sv
// Shared definitions for the max-pool stage and the LReLU stage feeding it.
package axis_maxpool_engine_pkg;

  // tuser bit positions on the max-pool input stream
  localparam int I_IS_NOT_MAX            = 0;
  localparam int I_IS_MAX                = 1;
  localparam int TUSER_WIDTH_MAXPOOL_IN  = 1 + I_IS_MAX;

  // pooling window phase: two beats per row pair, H captured on even phases
  typedef enum logic [1:0] {PH0, PH1, PH2, PH3} phase_e;

  // flat word index for copy c, group g, unit u
  function automatic int cgu_idx(input int c, input int g, input int u,
                                 input int groups, input int units);
    return (c * groups + g) * units + u;
  endfunction

endpackage

// File: rtl/axis_maxpool_engine_max2.sv
// Elementwise signed max of two N-word vectors; purely combinational.
module maxpool_max2 #(
  parameter int N          = 4,
  parameter int WORD_WIDTH = 8
) (
  input  logic [N-1:0][WORD_WIDTH-1:0] a,
  input  logic [N-1:0][WORD_WIDTH-1:0] b,
  output logic [N-1:0][WORD_WIDTH-1:0] y
);

  for (genvar i = 0; i < N; i++) begin : g_lane
    // ties pick a; both operands are identical then
    assign y[i] = ($signed(a[i]) >= $signed(b[i])) ? a[i] : b[i];
  end

endmodule

// File: rtl/axis_maxpool_engine.sv
// 2x2 / stride-2 signed max-pool on cgu-packed AXI-stream beats, with
// unpooled pass-through beats and a sticky flag for broken windows.
module axis_maxpool_engine
  import axis_maxpool_engine_pkg::*;
#(
  parameter int WORD_WIDTH   = 8,
  parameter int UNITS        = 8,
  parameter int GROUPS       = 2,
  parameter int COPIES       = 2,
  parameter int I_IS_NOT_MAX = axis_maxpool_engine_pkg::I_IS_NOT_MAX,
  parameter int I_IS_MAX     = axis_maxpool_engine_pkg::I_IS_MAX,
  parameter int TUSER_WIDTH  = 1 + I_IS_MAX
) (
  input  logic                                       aclk,
  input  logic                                       aresetn,
  input  logic                                       s_axis_tvalid,
  output logic                                       s_axis_tready,
  input  logic [COPIES*GROUPS*UNITS*WORD_WIDTH-1:0]  s_axis_tdata,
  input  logic [TUSER_WIDTH-1:0]                     s_axis_tuser,
  output logic                                       m_axis_tvalid,
  input  logic                                       m_axis_tready,
  output logic [COPIES*GROUPS*UNITS*WORD_WIDTH-1:0]  m_axis_tdata,
  output logic                                       m_axis_tuser,
  output logic                                       err_mode_break
);

  localparam int N  = COPIES * GROUPS * UNITS;
  localparam int HU = UNITS / 2;
  localparam int NH = N / 2;

  typedef logic [N-1:0][WORD_WIDTH-1:0]  vec_t;
  typedef logic [NH-1:0][WORD_WIDTH-1:0] hvec_t;

  vec_t   in_w, h_reg, h_max, pool_w;
  hvec_t  p_reg, v_a, v_b, v_max;
  phase_e phase, phase_nxt;

  logic s_fire, is_max, is_pass, pool_fire, pass_fire, win_done;

  assign in_w          = s_axis_tdata;
  assign s_axis_tready = !m_axis_tvalid || m_axis_tready;
  assign s_fire        = s_axis_tvalid && s_axis_tready;
  assign is_max        = s_axis_tuser[I_IS_MAX];
  assign is_pass       = !is_max && s_axis_tuser[I_IS_NOT_MAX];
  assign pool_fire     = s_fire && is_max;
  assign pass_fire     = s_fire && is_pass;
  assign win_done      = pool_fire && (phase == PH3);

  // horizontal max: stored left column against the incoming right column
  maxpool_max2 #(.N(N), .WORD_WIDTH(WORD_WIDTH)) u_hmax (
    .a(h_reg), .b(in_w), .y(h_max)
  );

  // vertical max: unit pairs (2k, 2k+1) of the horizontal result
  maxpool_max2 #(.N(NH), .WORD_WIDTH(WORD_WIDTH)) u_vmax (
    .a(v_a), .b(v_b), .y(v_max)
  );

  for (genvar c = 0; c < COPIES; c++) begin : g_c
    for (genvar g = 0; g < GROUPS; g++) begin : g_g
      for (genvar k = 0; k < HU; k++) begin : g_k
        assign v_a[cgu_idx(c, g, k, GROUPS, HU)] = h_max[cgu_idx(c, g, 2*k,   GROUPS, UNITS)];
        assign v_b[cgu_idx(c, g, k, GROUPS, HU)] = h_max[cgu_idx(c, g, 2*k+1, GROUPS, UNITS)];
        // first row pair fills the low half of each cg, second row pair the high half
        assign pool_w[cgu_idx(c, g, k,      GROUPS, UNITS)] = p_reg[cgu_idx(c, g, k, GROUPS, HU)];
        assign pool_w[cgu_idx(c, g, HU + k, GROUPS, UNITS)] = v_max[cgu_idx(c, g, k, GROUPS, HU)];
      end
    end
  end

  // phase register
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) phase <= PH0;
    else          phase <= phase_nxt;
  end

  // next phase: pooled beats advance, a pass-through beat abandons any partial window
  always_comb begin
    phase_nxt = phase;
    if (pass_fire)      phase_nxt = PH0;
    else if (pool_fire) phase_nxt = phase_e'(phase + 2'd1);
  end

  // window state: H on even phases, P after the first row pair
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      h_reg <= '0;
      p_reg <= '0;
    end else if (pool_fire) begin
      if (phase == PH0 || phase == PH2) h_reg <= in_w;
      if (phase == PH1)                 p_reg <= v_max;
    end
  end

  // output register; loads only on an accepted beat, which implies the slot is free
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
      m_axis_tuser  <= 1'b0;
    end else if (pass_fire) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= s_axis_tdata;
      m_axis_tuser  <= 1'b0;
    end else if (win_done) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= pool_w;
      m_axis_tuser  <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // sticky error when a pass-through beat cuts a pooled window short
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)                       err_mode_break <= 1'b0;
    else if (pass_fire && phase != PH0) err_mode_break <= 1'b1;
  end

endmodule

// File: tb/tb_axis_maxpool_engine.sv
// Scoreboard bench for axis_maxpool_engine: driver pushes expected beats,
// a negedge monitor pops and compares whenever an output beat is taken.
module tb_axis_maxpool_engine;
  import axis_maxpool_engine_pkg::*;

  localparam int W = 8, U = 8, G = 2, C = 2;
  localparam int N = C * G * U, DW = N * W;

  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct packed { vec_t d; logic u; } exp_t;

  logic          aclk = 0, aresetn = 0;
  logic          s_valid = 0, s_ready;
  logic [DW-1:0] s_data = '0;
  logic [1:0]    s_user = '0;
  logic          m_valid, m_ready = 0;
  logic [DW-1:0] m_data;
  logic          m_user, err;

  exp_t sb[$];
  int   errors = 0, checks = 0;

  axis_maxpool_engine dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
    .s_axis_tdata(s_data), .s_axis_tuser(s_user),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tdata(m_data), .m_axis_tuser(m_user),
    .err_mode_break(err)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] smax(input logic [W-1:0] a, input logic [W-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  // reference 2x2 pool: low half of each cg from rows b0/b1, high half from b2/b3
  function automatic vec_t pool4(input vec_t b0, input vec_t b1, input vec_t b2, input vec_t b3);
    vec_t r;
    for (int cg = 0; cg < C * G; cg++)
      for (int k = 0; k < U / 2; k++) begin
        r[cg*U + k]       = smax(smax(b0[cg*U+2*k], b1[cg*U+2*k]), smax(b0[cg*U+2*k+1], b1[cg*U+2*k+1]));
        r[cg*U + U/2 + k] = smax(smax(b2[cg*U+2*k], b3[cg*U+2*k]), smax(b2[cg*U+2*k+1], b3[cg*U+2*k+1]));
      end
    return r;
  endfunction

  function automatic vec_t rnd_vec();
    vec_t r;
    for (int i = 0; i < N; i++) r[i] = W'($urandom);
    return r;
  endfunction

  // present one beat and hold it until accepted (bounded)
  task automatic send(input vec_t d, input logic [1:0] u);
    int n = 0;
    s_data = d; s_user = u; s_valid = 1;
    @(negedge aclk);
    while (!s_ready && n < 200) begin @(negedge aclk); n++; end
    if (!s_ready) begin
      checks++; errors++;
      $display("FAIL send_timeout: s_axis_tready stuck at 0 expected 1");
    end
    @(posedge aclk); #1;
    s_valid = 0;
  endtask

  task automatic send_pass(input vec_t d);
    sb.push_back('{d: d, u: 1'b0});
    send(d, 2'b01);
  endtask

  task automatic send_window(input vec_t b0, input vec_t b1, input vec_t b2, input vec_t b3);
    sb.push_back('{d: pool4(b0, b1, b2, b3), u: 1'b1});
    send(b0, 2'b10); send(b1, 2'b10); send(b2, 2'b10); send(b3, 2'b10);
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 500) begin @(negedge aclk); n++; end
    @(posedge aclk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding expected 0", sb.size());
    end
  endtask

  // monitor: compare every taken output beat; check stall behaviour while held
  always @(negedge aclk) begin
    exp_t e;
    if (aresetn && m_valid) begin
      if (!m_ready) begin
        checks++;
        if (s_ready !== 1'b0) begin
          errors++;
          $display("FAIL hold_ready: s_axis_tready=%b expected 0", s_ready);
        end
      end else if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_beat: got %h tuser=%b expected none", m_data, m_user);
      end else begin
        e = sb.pop_front();
        chk("beat_data", m_data, e.d);
        chk("beat_tuser", DW'(m_user), DW'(e.u));
      end
    end
  end

  initial begin
    vec_t ramp, b0, b1, b2, b3, exp_v;

    // reset state
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_m_valid", DW'(m_valid), '0);
    chk("rst_m_data", m_data, '0);
    chk("rst_m_tuser", DW'(m_user), '0);
    chk("rst_err", DW'(err), '0);
    chk("rst_s_ready", DW'(s_ready), DW'(1));
    aresetn = 1;
    m_ready = 1;
    @(posedge aclk); #1;

    // pass-through: ramp 0..31, three beats, one-cycle latency
    for (int i = 0; i < N; i++) ramp[i] = W'(i);
    for (int b = 0; b < 3; b++) begin
      send_pass(ramp);
      chk("pass_latency", DW'(m_valid), DW'(1));
    end
    drain();

    // pooling pattern; b1 also has is_not_max set, which must still pool
    for (int i = 0; i < N; i++) begin
      b0[i] = W'(i % U); b1[i] = W'(-(i % U)); b2[i] = W'(10 + i % U); b3[i] = 8'h80;
    end
    for (int cg = 0; cg < C * G; cg++)
      for (int k = 0; k < U / 2; k++) begin
        exp_v[cg*U + k]       = W'(2*k + 1);
        exp_v[cg*U + U/2 + k] = W'(11 + 2*k);
      end
    sb.push_back('{d: exp_v, u: 1'b1});
    send(b0, 2'b10); send(b1, 2'b11); send(b2, 2'b10);
    chk("pool_no_early_out", DW'(m_valid), '0);
    send(b3, 2'b10);
    chk("pool_latency", DW'(m_valid), DW'(1));
    drain();

    // signed extremes: max(0x80,0x7F)=0x7F on the first row pair, max(0xFF,0x00)=0x00 on the second
    for (int i = 0; i < N; i++) begin
      b0[i] = 8'h80; b1[i] = 8'h7F; b2[i] = 8'hFF; b3[i] = 8'h00;
      exp_v[i] = ((i % U) < U/2) ? 8'h7F : 8'h00;
    end
    sb.push_back('{d: exp_v, u: 1'b1});
    send(b0, 2'b10); send(b1, 2'b10); send(b2, 2'b10); send(b3, 2'b10);
    drain();

    // back-pressure: held pass beat stalls a pooled window for 5 cycles
    m_ready = 0;
    send_pass(rnd_vec());
    fork
      send_window(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
      begin repeat (5) @(posedge aclk); #1; m_ready = 1; end
    join
    drain();

    // back-pressure: random ready mid-stream over two windows and a pass beat
    fork
      begin
        send_window(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
        send_pass(rnd_vec());
        send_window(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
      end
      begin
        repeat (30) begin @(posedge aclk); #1; m_ready = 1'($urandom_range(0, 1)); end
        m_ready = 1;
      end
    join
    m_ready = 1;
    drain();
    chk("err_clean", DW'(err), '0);

    // mode break: two pooled beats, a pass beat, then a full window
    send(rnd_vec(), 2'b10); send(rnd_vec(), 2'b10);
    send_pass(rnd_vec());
    send_window(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    drain();
    chk("err_mode_break", DW'(err), DW'(1));

    // dropped beat between ph1 and ph2 leaves the window intact
    b0 = rnd_vec(); b1 = rnd_vec(); b2 = rnd_vec(); b3 = rnd_vec();
    sb.push_back('{d: pool4(b0, b1, b2, b3), u: 1'b1});
    send(b0, 2'b10); send(b1, 2'b10);
    send(rnd_vec(), 2'b00);
    send(b2, 2'b10); send(b3, 2'b10);
    drain();

    // reset at ph2: partial window discarded, next four beats form a fresh window
    send(rnd_vec(), 2'b10); send(rnd_vec(), 2'b10);
    aresetn = 0;
    #1;
    chk("mid_rst_m_valid", DW'(m_valid), '0);
    chk("mid_rst_m_data", m_data, '0);
    chk("mid_rst_err", DW'(err), '0);
    @(posedge aclk); #1;
    aresetn = 1;
    send_window(rnd_vec(), rnd_vec(), rnd_vec(), rnd_vec());
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
